// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: PC/stall/flush from the pipeline, the instruction
// memory read channel, and the registered IF/ID payload towards decode.
interface inst_fetch_if;
    logic [31:0] pc_i;
    logic [5:0]  stall;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        stallreq_o;

    // master: the fetch stage itself
    modport master (
        input  pc_i, stall, flush_i, mem_ack_i, mem_rdata_i,
        output mem_req_o, mem_addr_o, if_pc_o, if_inst_o, if_valid_o, stallreq_o
    );

    // slave: pipeline control plus instruction memory around the fetch stage
    modport slave (
        output pc_i, stall, flush_i, mem_ack_i, mem_rdata_i,
        input  mem_req_o, mem_addr_o, if_pc_o, if_inst_o, if_valid_o, stallreq_o
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding memory read at a time, wrong-path
// reads drained (never abandoned), decode back-pressure absorbed by a one-entry buffer.
module inst_fetch #(
    parameter logic [31:0] INST_NOP = 32'h00000013
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic        req_reg, req_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] hold_pc_reg, hold_pc_next;
    logic [31:0] hold_inst_reg, hold_inst_next;
    logic [31:0] if_pc_reg, if_pc_next;
    logic [31:0] if_inst_reg, if_inst_next;
    logic        if_valid_reg, if_valid_next;

    logic stall_if;
    logic flush;
    logic ack;
    logic unused_stall;

    assign stall_if     = bus.stall[1];
    assign flush        = bus.flush_i;
    assign ack          = bus.mem_ack_i;
    assign unused_stall = ^{bus.stall[5:2], bus.stall[0]};

    // Sequencing of the single outstanding read and the back-pressure buffer
    always_comb begin
        state_next     = state_reg;
        req_next       = req_reg;
        addr_next      = addr_reg;
        hold_pc_next   = hold_pc_reg;
        hold_inst_next = hold_inst_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!flush) begin
                    addr_next  = bus.pc_i;
                    req_next   = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack) begin
                    req_next = 1'b0;
                    if (!flush && stall_if) begin
                        hold_pc_next   = addr_reg;
                        hold_inst_next = bus.mem_rdata_i;
                        state_next     = ST_HOLD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (flush) begin
                    state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                // The wrong-path read must still complete before a new one starts.
                if (ack) begin
                    req_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!stall_if || flush) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // IF/ID payload: flush beats stall, stall beats any new word
    always_comb begin
        if_pc_next    = if_pc_reg;
        if_inst_next  = if_inst_reg;
        if_valid_next = if_valid_reg;
        if (flush) begin
            if_pc_next    = 32'h0;
            if_inst_next  = INST_NOP;
            if_valid_next = 1'b0;
        end else if (stall_if) begin
            if_pc_next    = if_pc_reg;
            if_inst_next  = if_inst_reg;
            if_valid_next = if_valid_reg;
        end else if (state_reg == ST_WAIT && ack) begin
            if_pc_next    = addr_reg;
            if_inst_next  = bus.mem_rdata_i;
            if_valid_next = 1'b1;
        end else if (state_reg == ST_HOLD) begin
            if_pc_next    = hold_pc_reg;
            if_inst_next  = hold_inst_reg;
            if_valid_next = 1'b1;
        end else begin
            if_pc_next    = 32'h0;
            if_inst_next  = INST_NOP;
            if_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            req_reg       <= 1'b0;
            addr_reg      <= 32'h0;
            hold_pc_reg   <= 32'h0;
            hold_inst_reg <= 32'h0;
            if_pc_reg     <= 32'h0;
            if_inst_reg   <= INST_NOP;
            if_valid_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            req_reg       <= req_next;
            addr_reg      <= addr_next;
            hold_pc_reg   <= hold_pc_next;
            hold_inst_reg <= hold_inst_next;
            if_pc_reg     <= if_pc_next;
            if_inst_reg   <= if_inst_next;
            if_valid_reg  <= if_valid_next;
        end
    end

    // PC and IF hold whenever a fetch is in flight or parked
    assign bus.stallreq_o = (state_reg != ST_IDLE);
    assign bus.mem_req_o  = req_reg;
    assign bus.mem_addr_o = addr_reg;
    assign bus.if_pc_o    = if_pc_reg;
    assign bus.if_inst_o  = if_inst_reg;
    assign bus.if_valid_o = if_valid_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_inst_fetch;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   cmp_en;

    inst_fetch_if bus ();

    inst_fetch #(.INST_NOP(32'h00000013)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a fetch is "busy" while its read is outstanding, "doomed" once a
    // flush has made it wrong-path, "buffered" while decode refuses the word.
    bit          m_busy;
    bit          m_doomed;
    bit          m_buf;
    logic [31:0] m_addr;
    logic [31:0] m_buf_pc;
    logic [31:0] m_buf_inst;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    bit          e_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_doomed = 0; m_buf = 0;
        m_addr = 0; m_buf_pc = 0; m_buf_inst = 0;
        e_pc = 0; e_inst = 32'h00000013; e_valid = 0;
    endtask

    task automatic model_step();
        bit was_busy, was_buf, s1, f, a, lands;
        was_busy = m_busy;
        was_buf  = m_buf;
        s1 = bus.stall[1];
        f  = bus.flush_i;
        a  = bus.mem_ack_i;
        lands = m_busy && a && !m_doomed && !f;
        if (f) begin
            e_pc = 0; e_inst = 32'h00000013; e_valid = 0;
        end else if (s1) begin
            e_valid = e_valid;
        end else if (lands) begin
            e_pc = m_addr; e_inst = bus.mem_rdata_i; e_valid = 1;
        end else if (m_buf) begin
            e_pc = m_buf_pc; e_inst = m_buf_inst; e_valid = 1;
        end else begin
            e_pc = 0; e_inst = 32'h00000013; e_valid = 0;
        end
        if (was_buf && (f || !s1)) m_buf = 0;
        if (was_busy) begin
            if (a) begin
                m_busy = 0;
                m_doomed = 0;
                if (lands && s1) begin
                    m_buf = 1; m_buf_pc = m_addr; m_buf_inst = bus.mem_rdata_i;
                end
            end else if (f) begin
                m_doomed = 1;
            end
        end else if (!was_buf && !f) begin
            m_busy = 1;
            m_addr = bus.pc_i;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input bit s1, input bit f,
                         input bit a, input logic [31:0] rd);
        bus.pc_i        = pc;
        bus.stall       = {4'b0, s1, 1'b0};
        bus.flush_i     = f;
        bus.mem_ack_i   = a;
        bus.mem_rdata_i = rd;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req",      {31'b0, bus.mem_req_o},  {31'b0, m_busy});
            chk("addr",     bus.mem_addr_o,          m_addr);
            chk("stallreq", {31'b0, bus.stallreq_o}, {31'b0, (m_busy || m_buf)});
            chk("if_pc",    bus.if_pc_o,             e_pc);
            chk("if_inst",  bus.if_inst_o,           e_inst);
            chk("if_valid", {31'b0, bus.if_valid_o}, {31'b0, e_valid});
        end
    end

    initial begin
        int n_stall;
        int n_valid;
        checks = 0;
        errors = 0;
        cmp_en = 0;
        rst = 1'b0;
        model_reset();
        drive(32'h0, 0, 0, 0, 32'h0);
        tick();
        tick();
        cmp_en = 1;
        chk("rst_req",   {31'b0, bus.mem_req_o}, 32'h0);
        chk("rst_inst",  bus.if_inst_o, 32'h00000013);
        chk("rst_valid", {31'b0, bus.if_valid_o}, 32'h0);
        chk("rst_stallreq", {31'b0, bus.stallreq_o}, 32'h0);
        rst = 1'b1;

        // Zero-wait fetch: latch, then word lands on the next edge
        drive(32'h0, 0, 0, 0, 32'h0);
        tick();
        chk("zw_req",  {31'b0, bus.mem_req_o}, 32'h1);
        chk("zw_addr", bus.mem_addr_o, 32'h0);
        drive(32'h0, 0, 0, 1, 32'h00500093);
        tick();
        chk("zw_pc",    bus.if_pc_o, 32'h0);
        chk("zw_inst",  bus.if_inst_o, 32'h00500093);
        chk("zw_valid", {31'b0, bus.if_valid_o}, 32'h1);
        chk("zw_req_fall", {31'b0, bus.mem_req_o}, 32'h0);

        // Three wait states at pc 4
        drive(32'h4, 0, 0, 0, 32'h0);
        tick();
        n_stall = 0;
        n_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.stallreq_o) n_stall++;
            chk("ws_addr", bus.mem_addr_o, 32'h4);
            if (i == 3) drive(32'h4, 0, 0, 1, 32'h00A00113);
            tick();
            if (bus.if_valid_o) n_valid++;
        end
        drive(32'h8, 0, 0, 0, 32'h0);
        chk("ws_stall_cycles", n_stall, 32'd4);
        chk("ws_valid_count", n_valid, 32'd1);
        chk("ws_pc", bus.if_pc_o, 32'h4);
        chk("ws_inst", bus.if_inst_o, 32'h00A00113);

        // Decode stall: word parked in the buffer for two cycles
        tick();
        drive(32'h8, 1, 0, 1, 32'h002081B3);
        tick();
        drive(32'h8, 1, 0, 0, 32'h0);
        chk("hold_stallreq", {31'b0, bus.stallreq_o}, 32'h1);
        chk("hold_valid", {31'b0, bus.if_valid_o}, 32'h0);
        tick();
        chk("hold_valid2", {31'b0, bus.if_valid_o}, 32'h0);
        drive(32'hC, 0, 0, 0, 32'h0);
        tick();
        chk("hold_pc", bus.if_pc_o, 32'h8);
        chk("hold_inst", bus.if_inst_o, 32'h002081B3);
        chk("hold_valid3", {31'b0, bus.if_valid_o}, 32'h1);
        chk("hold_idle", {31'b0, bus.stallreq_o}, 32'h0);

        // Flush in flight: drain the wrong-path read, then fetch the redirect
        tick();
        drive(32'hC, 0, 1, 0, 32'h0);
        tick();
        chk("drop_req", {31'b0, bus.mem_req_o}, 32'h1);
        chk("drop_inst", bus.if_inst_o, 32'h00000013);
        chk("drop_valid", {31'b0, bus.if_valid_o}, 32'h0);
        drive(32'h40, 0, 0, 0, 32'h0);
        tick();
        chk("drop_addr", bus.mem_addr_o, 32'hC);
        drive(32'h40, 0, 0, 1, 32'hDEADBEEF);
        tick();
        chk("drop_discard", {31'b0, bus.if_valid_o}, 32'h0);
        chk("drop_req_fall", {31'b0, bus.mem_req_o}, 32'h0);
        drive(32'h40, 0, 0, 0, 32'h0);
        tick();
        chk("redir_addr", bus.mem_addr_o, 32'h40);
        drive(32'h40, 0, 0, 1, 32'h00000073);
        tick();
        chk("redir_pc", bus.if_pc_o, 32'h40);

        // Flush in IDLE issues nothing; flush with ack discards the word
        drive(32'h50, 0, 1, 0, 32'h0);
        tick();
        chk("idle_flush_req", {31'b0, bus.mem_req_o}, 32'h0);
        drive(32'h60, 0, 0, 0, 32'h0);
        tick();
        drive(32'h60, 0, 1, 1, 32'h11111111);
        tick();
        chk("ack_flush_valid", {31'b0, bus.if_valid_o}, 32'h0);
        chk("ack_flush_idle", {31'b0, bus.stallreq_o}, 32'h0);

        // Flush while parked in HOLD
        drive(32'h70, 0, 0, 0, 32'h0);
        tick();
        drive(32'h70, 1, 0, 1, 32'h22222222);
        tick();
        drive(32'h70, 1, 1, 0, 32'h0);
        tick();
        chk("hold_flush_valid", {31'b0, bus.if_valid_o}, 32'h0);
        chk("hold_flush_idle", {31'b0, bus.stallreq_o}, 32'h0);

        // Asynchronous reset mid-fetch, late ack ignored afterwards
        drive(32'h80, 0, 0, 0, 32'h0);
        tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_req", {31'b0, bus.mem_req_o}, 32'h0);
        chk("arst_valid", {31'b0, bus.if_valid_o}, 32'h0);
        chk("arst_addr", bus.mem_addr_o, 32'h0);
        tick();
        rst = 1'b1;
        drive(32'h100, 0, 0, 1, 32'h33333333);
        tick();
        chk("late_ack_valid", {31'b0, bus.if_valid_o}, 32'h0);
        chk("first_req_addr", bus.mem_addr_o, 32'h100);
        drive(32'h100, 0, 0, 0, 32'h0);
        tick();
        drive(32'h100, 0, 0, 1, 32'h00100513);
        tick();
        chk("post_rst_inst", bus.if_inst_o, 32'h00100513);
        drive(32'h104, 0, 0, 0, 32'h0);
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter INST_NOP, default 32'h00000013, the instruction word driven on bubbles and flushes.
REQ-002 The block SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port pc_i  input  32  current fetch address from the PC register.
REQ-005 The block SHALL have port stall  input  6  pipeline stall vector; bit 0 = PC, bit 1 = IF/ID.
REQ-006 The block SHALL have port flush_i  input  1  branch/jump taken in ID or EX; the current fetch is wrong-path.
REQ-007 The block SHALL have port mem_req_o  output  1  instruction memory read request, registered.
REQ-008 The block SHALL have port mem_addr_o  output  32  read address, registered.
REQ-009 The block SHALL have port mem_ack_i  input  1  single-cycle read-complete pulse.
REQ-010 The block SHALL have port mem_rdata_i  input  32  read data, valid only while mem_ack_i=1.
REQ-011 The block SHALL have ports if_pc_o, if_inst_o, if_valid_o  output  32/32/1  registered IF/ID payload to decode.
REQ-012 The block SHALL have port stallreq_o  output  1  combinational request to hold the PC and IF stages.

Function
REQ-013 The FSM SHALL have four states: IDLE, WAIT, HOLD and DROP.
REQ-014 In IDLE with flush_i=0, the block SHALL at the clock edge latch mem_addr_o<=pc_i, set mem_req_o<=1 and enter WAIT.
REQ-015 In IDLE with flush_i=1, the block SHALL issue no request and stay in IDLE, since pc_i is wrong-path.
REQ-016 In WAIT and DROP, mem_req_o SHALL be 1 and mem_addr_o SHALL stay constant until the cycle mem_ack_i=1.
REQ-017 mem_ack_i SHALL be ignored in IDLE and HOLD.
REQ-018 In WAIT with mem_ack_i=1 and flush_i=0: if stall[1]=0 the block SHALL go to IDLE; otherwise it SHALL store {mem_addr_o, mem_rdata_i} in the hold buffer and go to HOLD.
REQ-019 In WAIT with mem_ack_i=1 and flush_i=1, the block SHALL discard the data and go to IDLE.
REQ-020 In WAIT with flush_i=1 and mem_ack_i=0, the block SHALL go to DROP.
REQ-021 DROP SHALL be exited to IDLE on mem_ack_i=1, discarding the data; a request is never abandoned mid-flight.
REQ-022 mem_req_o SHALL fall to 0 on the edge that leaves WAIT or DROP.
REQ-023 HOLD SHALL be left for IDLE when stall[1]=0 or flush_i=1.
REQ-024 stallreq_o SHALL equal (state != IDLE), so the PC advances exactly once per fetch, on the IDLE-cycle edge.
REQ-025 Output register priority at each edge, highest first:
- flush_i=1 -> if_inst_o<=INST_NOP, if_pc_o<=0, if_valid_o<=0, regardless of stall[1].
- stall[1]=1 -> outputs hold.
- WAIT with mem_ack_i=1 -> load {mem_addr_o, mem_rdata_i}, valid 1.
- HOLD -> load the hold buffer, valid 1.
- otherwise -> bubble: INST_NOP, pc 0, valid 0.
REQ-026 With zero-wait memory (ack in the first WAIT cycle), throughput SHALL be one instruction per 2 cycles; latency from IDLE latch to if_valid_o=1 is 2 edges.

Reset
REQ-027 While rst=0, asynchronously and independent of clk, the block SHALL force: state=IDLE, mem_req_o=0, mem_addr_o=0, if_pc_o=0, if_inst_o=INST_NOP, if_valid_o=0, hold buffer=0.
REQ-028 Reset asserted mid-transaction (WAIT or DROP) SHALL abort it; any mem_ack_i after reset release while in IDLE is ignored.
REQ-029 The first request after reset release SHALL be issued on the first rising edge with rst=1 and flush_i=0.

Verification
REQ-030 Zero-wait fetch: pc_i=0x0, ack the cycle after the request with rdata 0x00500093 -> mem_addr_o=0x0; two edges later if_pc_o=0x0, if_inst_o=0x00500093, if_valid_o=1.
REQ-031 Wait states: ack delayed 3 cycles for pc_i=0x4 -> stallreq_o=1 for 4 cycles, mem_addr_o stable at 0x4, pc_i not advanced, exactly one valid output.
REQ-032 Decode stall: ack arrives with stall[1]=1 for 2 cycles -> state HOLD, outputs unchanged; on stall[1]=0 the buffered pc and inst appear with valid=1.
REQ-033 Flush in flight: flush_i=1 in WAIT, ack 2 cycles later -> DROP, mem_req_o stays 1 until ack, if_valid_o=0 with if_inst_o=0x00000013, next request uses the redirected pc_i.
REQ-034 Reset mid-fetch: rst=0 pulsed during WAIT -> mem_req_o=0 and if_valid_o=0 immediately without a clock edge; a late ack is ignored.
